// File: rtl/amber_boot_loader_pkg.sv
// Shared constants for the amber boot loader: frame header byte, error codes, state encodings.
// Benches import this package to decode state and error values.
package amber_boot_loader_pkg;

    localparam logic [7:0] BOOT_HDR = 8'hA5;

    typedef enum logic [1:0] {
        BOOT_ERR_NONE    = 2'b00,
        BOOT_ERR_CSUM    = 2'b01,
        BOOT_ERR_COUNT   = 2'b10,
        BOOT_ERR_TIMEOUT = 2'b11
    } boot_err_e;

    typedef enum logic [2:0] {
        BOOT_ST_IDLE   = 3'd0,
        BOOT_ST_CNT_HI = 3'd1,
        BOOT_ST_CNT_LO = 3'd2,
        BOOT_ST_DATA0  = 3'd3,
        BOOT_ST_DATA1  = 3'd4,
        BOOT_ST_DATA2  = 3'd5,
        BOOT_ST_CSUM   = 3'd6,
        BOOT_ST_RUN    = 3'd7
    } boot_state_e;

endpackage

// File: rtl/amber_boot_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles, cleared by activity, pulses expire at LIMIT.
module amber_boot_timeout #(
    parameter int LIMIT = 16
) (
    input  logic iw_clk,
    input  logic iw_rst_n,
    input  logic iw_clear,
    input  logic iw_en,
    output logic ow_expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_reg;

    // Expiry is suppressed in a cycle with activity, so a byte arriving on the last cycle still counts.
    assign ow_expire = iw_en & ~iw_clear & (cnt_reg == CW'(LIMIT - 1));

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n || iw_clear || ow_expire) begin
            cnt_reg <= '0;
        end else if (iw_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/amber_boot_loader.sv
// Framed byte-stream program loader: writes 24-bit words into instruction memory from address 0
// and releases the core from reset once a frame with a matching checksum has been loaded.
module amber_boot_loader
    import amber_boot_loader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [7:0]        iw_rx_data,
    input  logic              iw_rx_valid,
    output logic              ow_rx_ready,
    input  logic              iw_reboot,
    output logic              ow_imem_we,
    output logic [ADDR_W-1:0] ow_imem_addr,
    output logic [23:0]       ow_imem_wdata,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err,
    output logic [1:0]        ow_err_code
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(1);

    boot_state_e       state_reg;
    boot_err_e         err_code_reg;
    logic [7:0]        sum_reg;
    logic [7:0]        cnt_hi_reg;
    logic [7:0]        byte_hi_reg;
    logic [7:0]        byte_mid_reg;
    logic [ADDR_W:0]   words_left_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [23:0]       wdata_reg;
    logic              core_rst_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic              accept;
    logic              expire;
    logic [15:0]       cnt_full;

    assign ow_rx_ready = (state_reg != BOOT_ST_RUN) & ~iw_reboot;
    assign accept      = iw_rx_valid & ow_rx_ready;
    assign cnt_full    = {cnt_hi_reg, iw_rx_data};

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            amber_boot_timeout #(
                .LIMIT(TIMEOUT_CYC)
            ) u_timeout (
                .iw_clk   (iw_clk),
                .iw_rst_n (iw_rst_n),
                .iw_clear (accept | iw_reboot),
                .iw_en    (busy_reg),
                .ow_expire(expire)
            );
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state_reg      <= BOOT_ST_IDLE;
            err_code_reg   <= BOOT_ERR_NONE;
            sum_reg        <= '0;
            cnt_hi_reg     <= '0;
            byte_hi_reg    <= '0;
            byte_mid_reg   <= '0;
            words_left_reg <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            core_rst_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            // The address advances once the word presented on the write port has retired.
            if (we_reg) begin
                addr_reg <= addr_reg + 1'b1;
            end

            if (iw_reboot) begin
                state_reg    <= BOOT_ST_IDLE;
                core_rst_reg <= 1'b1;
                done_reg     <= 1'b0;
                busy_reg     <= 1'b0;
                addr_reg     <= '0;
            end else if (expire) begin
                state_reg    <= BOOT_ST_IDLE;
                busy_reg     <= 1'b0;
                err_reg      <= 1'b1;
                err_code_reg <= BOOT_ERR_TIMEOUT;
            end else if (accept) begin
                case (state_reg)
                    BOOT_ST_IDLE: begin
                        if (iw_rx_data == BOOT_HDR) begin
                            state_reg    <= BOOT_ST_CNT_HI;
                            busy_reg     <= 1'b1;
                            err_reg      <= 1'b0;
                            err_code_reg <= BOOT_ERR_NONE;
                            sum_reg      <= '0;
                            addr_reg     <= '0;
                        end
                    end
                    BOOT_ST_CNT_HI: begin
                        cnt_hi_reg <= iw_rx_data;
                        sum_reg    <= sum_reg + iw_rx_data;
                        state_reg  <= BOOT_ST_CNT_LO;
                    end
                    BOOT_ST_CNT_LO: begin
                        sum_reg        <= sum_reg + iw_rx_data;
                        words_left_reg <= (ADDR_W + 1)'(cnt_full);
                        if ({16'd0, cnt_full} > 32'(DEPTH)) begin
                            state_reg    <= BOOT_ST_IDLE;
                            busy_reg     <= 1'b0;
                            err_reg      <= 1'b1;
                            err_code_reg <= BOOT_ERR_COUNT;
                        end else if (cnt_full == 16'd0) begin
                            state_reg <= BOOT_ST_CSUM;
                        end else begin
                            state_reg <= BOOT_ST_DATA0;
                        end
                    end
                    BOOT_ST_DATA0: begin
                        byte_hi_reg <= iw_rx_data;
                        sum_reg     <= sum_reg + iw_rx_data;
                        state_reg   <= BOOT_ST_DATA1;
                    end
                    BOOT_ST_DATA1: begin
                        byte_mid_reg <= iw_rx_data;
                        sum_reg      <= sum_reg + iw_rx_data;
                        state_reg    <= BOOT_ST_DATA2;
                    end
                    BOOT_ST_DATA2: begin
                        wdata_reg      <= {byte_hi_reg, byte_mid_reg, iw_rx_data};
                        we_reg         <= 1'b1;
                        sum_reg        <= sum_reg + iw_rx_data;
                        words_left_reg <= words_left_reg - 1'b1;
                        state_reg      <= (words_left_reg == LAST_WORD) ? BOOT_ST_CSUM : BOOT_ST_DATA0;
                    end
                    BOOT_ST_CSUM: begin
                        busy_reg <= 1'b0;
                        if (iw_rx_data == sum_reg) begin
                            state_reg    <= BOOT_ST_RUN;
                            core_rst_reg <= 1'b0;
                            done_reg     <= 1'b1;
                        end else begin
                            state_reg    <= BOOT_ST_IDLE;
                            err_reg      <= 1'b1;
                            err_code_reg <= BOOT_ERR_CSUM;
                        end
                    end
                    default: begin
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    assign ow_imem_we    = we_reg;
    assign ow_imem_addr  = addr_reg;
    assign ow_imem_wdata = wdata_reg;
    assign ow_core_rst   = core_rst_reg;
    assign ow_busy       = busy_reg;
    assign ow_done       = done_reg;
    assign ow_err        = err_reg;
    assign ow_err_code   = err_code_reg;

endmodule

// File: tb/tb_amber_boot_loader.sv
// Bench for amber_boot_loader: fixed frame table, randomized frames against a frame-level model,
// and hand sequences for timeout, reboot and reset corner cases.
module tb_amber_boot_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int TOUT   = 16;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reboot;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [23:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;

    amber_boot_loader #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_rx_data   (rx_data),
        .iw_rx_valid  (rx_valid),
        .ow_rx_ready  (rx_ready),
        .iw_reboot    (reboot),
        .ow_imem_we   (imem_we),
        .ow_imem_addr (imem_addr),
        .ow_imem_wdata(imem_wdata),
        .ow_core_rst  (core_rst),
        .ow_busy      (busy),
        .ow_done      (done),
        .ow_err       (err),
        .ow_err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed imem writes as {addr, data}.
    logic [35:0] wr_q[$];
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One clock cycle: inputs held across the rising edge, returns at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rb);
        rx_valid = v;
        rx_data  = d;
        reboot   = rb;
        @(negedge clk);
        rx_valid = 1'b0;
        reboot   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_bytes(input logic [95:0] bytes, input int len);
        for (int k = 0; k < len; k++) step(1'b1, bytes[95 - 8*k -: 8], 1'b0);
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0]  fq[$];
    logic [35:0] exp_q[$];
    logic        m_done;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic model_frame();
        int         i;
        int         cnt;
        logic [7:0] sum;
        logic [23:0] w;
        exp_q.delete();
        m_done = 1'b0;
        i = 0;
        while (i < fq.size() && fq[i] != 8'hA5) i++;
        if (i >= fq.size()) return;
        i++;
        m_err  = 1'b0;
        m_code = 2'd0;
        cnt = int'({fq[i], fq[i+1]});
        sum = fq[i] + fq[i+1];
        i += 2;
        if (cnt > DEPTH) begin
            m_err  = 1'b1;
            m_code = 2'd2;
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            w = {fq[i], fq[i+1], fq[i+2]};
            sum = sum + fq[i] + fq[i+1] + fq[i+2];
            exp_q.push_back({12'(k), w});
            i += 3;
        end
        if (fq[i] == sum) begin
            m_done = 1'b1;
        end else begin
            m_err  = 1'b1;
            m_code = 2'd1;
        end
    endtask

    // ---------------- directed frame table ----------------
    typedef struct {
        string       name;
        int          len;
        logic [95:0] bytes;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_nwr;
        logic [23:0] exp_w0;
        logic [23:0] exp_w1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] csum;
        int         cnt;
        int         ngar;
        logic [7:0] b;

        vecs[0] = '{"good2",   10, 96'hA5_00_02_30_10_00_72_10_03_C7_00_00, 1, 0, 2'd0, 2, 24'h301000, 24'h721003};
        vecs[1] = '{"badcsum", 10, 96'hA5_00_02_30_10_00_72_10_03_C8_00_00, 0, 1, 2'd1, 2, 24'h301000, 24'h721003};
        vecs[2] = '{"regood",  10, 96'hA5_00_02_30_10_00_72_10_03_C7_00_00, 1, 0, 2'd0, 2, 24'h301000, 24'h721003};
        vecs[3] = '{"cnt4097",  3, 96'hA5_10_01_00_00_00_00_00_00_00_00_00, 0, 1, 2'd2, 0, 24'h0, 24'h0};
        vecs[4] = '{"empty",    6, 96'h00_FF_A5_00_00_00_00_00_00_00_00_00, 1, 0, 2'd0, 0, 24'h0, 24'h0};
        vecs[5] = '{"garbage",  3, 96'h00_FF_12_00_00_00_00_00_00_00_00_00, 0, 0, 2'd0, 0, 24'h0, 24'h0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reboot   = 1'b0;
        @(negedge clk);
        idle(2);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_flags", {busy, done, err, err_code}, 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_ready", rx_ready, 1);

        for (int v = 0; v < 6; v++) begin
            step(1'b0, 8'h00, 1'b1);
            wr_q.delete();
            send_bytes(vecs[v].bytes, vecs[v].len);
            idle(3);
            chk({vecs[v].name, "_done"}, done, vecs[v].exp_done);
            chk({vecs[v].name, "_core_rst"}, core_rst, !vecs[v].exp_done);
            chk({vecs[v].name, "_err"}, {err, err_code}, {vecs[v].exp_err, vecs[v].exp_code});
            chk({vecs[v].name, "_busy"}, busy, 0);
            chk({vecs[v].name, "_nwr"}, wr_q.size(), vecs[v].exp_nwr);
            if (vecs[v].exp_nwr >= 1 && wr_q.size() >= 1)
                chk({vecs[v].name, "_w0"}, wr_q[0], {12'd0, vecs[v].exp_w0});
            if (vecs[v].exp_nwr >= 2 && wr_q.size() >= 2)
                chk({vecs[v].name, "_w1"}, wr_q[1], {12'd1, vecs[v].exp_w1});
        end

        // ---------------- randomized frames vs model ----------------
        m_err  = 1'b0;
        m_code = 2'd0;
        for (int f = 0; f < 40; f++) begin
            fq.delete();
            ngar = $urandom_range(0, 2);
            for (int g = 0; g < ngar; g++) begin
                b = 8'($urandom_range(0, 255));
                fq.push_back(b == 8'hA5 ? 8'h00 : b);
            end
            fq.push_back(8'hA5);
            if ($urandom_range(0, 9) == 0) begin
                cnt = DEPTH + 1 + $urandom_range(0, 60000);
                fq.push_back(cnt[15:8]);
                fq.push_back(cnt[7:0]);
            end else begin
                cnt = $urandom_range(0, 6);
                fq.push_back(cnt[15:8]);
                fq.push_back(cnt[7:0]);
                csum = cnt[15:8] + cnt[7:0];
                for (int k = 0; k < 3*cnt; k++) begin
                    b = 8'($urandom_range(0, 255));
                    fq.push_back(b);
                    csum = csum + b;
                end
                if ($urandom_range(0, 3) == 0) csum = csum ^ 8'($urandom_range(1, 255));
                fq.push_back(csum);
            end
            model_frame();

            step(1'b0, 8'h00, 1'b1);
            wr_q.delete();
            for (int k = 0; k < fq.size(); k++) begin
                idle($urandom_range(0, 3));
                step(1'b1, fq[k], 1'b0);
            end
            idle(3);
            chk($sformatf("rnd%0d_status", f), {done, core_rst, err, err_code, busy},
                {m_done, !m_done, m_err, m_code, 1'b0});
            chk($sformatf("rnd%0d_nwr", f), wr_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
                chk($sformatf("rnd%0d_wr%0d", f, k), wr_q[k], exp_q[k]);
        end

        // ---------------- timeout ----------------
        step(1'b0, 8'h00, 1'b1);
        send_bytes(96'hA5_00_01_30_00_00_00_00_00_00_00_00, 4);
        idle(TOUT - 1);
        chk("tout_before_busy", {busy, err}, 2'b10);
        idle(1);
        chk("tout_err", {err, err_code}, 3'b111);
        chk("tout_state", {busy, done, core_rst}, 3'b001);
        step(1'b0, 8'h00, 1'b1);
        chk("tout_reboot_keeps_err", {err, err_code}, 3'b111);

        // ---------------- reboot while running, with a byte offered ----------------
        send_bytes(96'hA5_00_02_30_10_00_72_10_03_C7_00_00, 10);
        idle(1);
        chk("run_done", {done, core_rst, rx_ready}, 3'b100);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        reboot   = 1'b1;
        #1;
        chk("reboot_ready", rx_ready, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        reboot   = 1'b0;
        chk("reboot_run", {core_rst, done, busy, err}, 4'b1000);
        chk("reboot_addr", imem_addr, 0);

        // ---------------- reboot mid-DATA1 ----------------
        wr_q.delete();
        send_bytes(96'hA5_00_02_30_10_00_72_00_00_00_00_00, 7);
        step(1'b0, 8'h00, 1'b1);
        send_bytes(96'h10_03_C7_00_00_00_00_00_00_00_00_00, 3);
        idle(3);
        chk("mid_reboot_nwr", wr_q.size(), 1);
        chk("mid_reboot_state", {busy, done, core_rst}, 3'b001);
        chk("mid_reboot_addr", imem_addr, 0);

        // ---------------- reset mid-frame ----------------
        step(1'b0, 8'h00, 1'b1);
        send_bytes(96'hA5_00_02_30_10_00_72_00_00_00_00_00, 7);
        chk("pre_rst_addr_data", {imem_addr, imem_wdata}, {12'd1, 24'h301000});
        rst_n = 1'b0;
        idle(1);
        chk("midrst_outs", {imem_we, imem_addr, imem_wdata}, 0);
        chk("midrst_flags", {core_rst, busy, done, err, err_code}, 6'b100000);
        rst_n = 1'b1;
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
